uart_rx_core_param: RTL and testbench

Parametrised UART receive engine with a built-in receive FIFO. It is the next-generation RX path behind the APB UART register block. It oversamples `UART_RXD` and supports run-time frame formats: 5..DATA_W data bits, none/even/odd parity, and 1 or 2 stop bits. Each received word is pushed into a first-word-fall-through FIFO together with per-word error flags, and the APB side drains the FIFO through a valid/ready pop port.

---
 rtl/uart_rx_core_param.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_uart_rx_core_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core_param.sv
// uart_rx_core_param: oversampling UART receive engine with a first-word-fall-through
// receive FIFO. Frame format (data bits, parity, stop bits) is captured at each start
// edge. Every received word is queued with its {break, framing, parity} flags.

module uart_rx_core_param #(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OSR        = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          os_tick,
    input  logic                          rx_en,
    input  logic [3:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          UART_RXD,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_W-1:0]             rd_data,
    output logic [2:0]                    rd_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          rx_busy
);

    localparam int unsigned CntW = $clog2(OSR);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = AddrW + 1;
    localparam int unsigned WordW = DATA_W + 3;

    // Sample points around mid-bit and the last tick of a bit.
    localparam logic [CntW-1:0] CntS0  = CntW'(OSR / 2 - 1);
    localparam logic [CntW-1:0] CntS1  = CntW'(OSR / 2);
    localparam logic [CntW-1:0] CntS2  = CntW'(OSR / 2 + 1);
    localparam logic [CntW-1:0] CntEnd = CntW'(OSR - 1);

    localparam logic [3:0] MinBits = 4'd5;
    localparam logic [3:0] MaxBits = 4'(DATA_W);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizer and start-edge detect
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rxs;
    logic       rxs_prev_q;
    logic       start_edge;

    // Two-flop synchronizer on the async line, plus one-cycle history of rxs.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], UART_RXD};
            rxs_prev_q <= rxs;
        end
    end

    assign rxs        = sync_q[1];
    assign start_edge = rxs_prev_q & ~rxs;

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [1:0]          smp_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [3:0]          bit_idx_q;
    logic [3:0]          nbits_q;
    logic                par_en_q;
    logic                par_odd_q;
    logic                two_stop_q;
    logic                par_acc_q;
    logic                zero_q;
    logic                perr_q;
    logic                ferr_q;
    logic                brk_q;
    logic                push_q;
    logic [WordW-1:0]    push_word_q;

    logic [3:0]          nbits_clamped;
    logic                tick_s0;
    logic                tick_s1;
    logic                decide;
    logic                bit_end;
    logic                maj;

    // Clamp the requested data-bit count into 5..DATA_W.
    always_comb begin
        nbits_clamped = data_bits;
        if (data_bits < MinBits) begin
            nbits_clamped = MinBits;
        end else if (data_bits > MaxBits) begin
            nbits_clamped = MaxBits;
        end
    end

    // Decode the oversample phase and form the 2-of-3 majority at the third sample.
    always_comb begin
        tick_s0 = os_tick && (cnt_q == CntS0);
        tick_s1 = os_tick && (cnt_q == CntS1);
        decide  = os_tick && (cnt_q == CntS2);
        bit_end = os_tick && (cnt_q == CntEnd);
        maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    end

    // Receive FSM with bit-phase counter; push request and word are registered here.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            smp_q       <= '0;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            nbits_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            par_acc_q   <= 1'b0;
            zero_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q <= 1'b0;
            if ((state_q != StIdle) && !rx_en) begin
                // Receiver disabled mid-frame: abandon it without pushing.
                state_q <= StIdle;
            end else begin
                if ((state_q != StIdle) && os_tick) begin
                    cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                    if (tick_s0) smp_q[0] <= rxs;
                    if (tick_s1) smp_q[1] <= rxs;
                end

                unique case (state_q)
                    StIdle: begin
                        if (rx_en && start_edge) begin
                            state_q    <= StStart;
                            cnt_q      <= '0;
                            nbits_q    <= nbits_clamped;
                            par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                            par_odd_q  <= (parity_mode == 2'b10);
                            two_stop_q <= stop_bits;
                            shreg_q    <= '0;
                            bit_idx_q  <= '0;
                            par_acc_q  <= 1'b0;
                            zero_q     <= 1'b1;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                            brk_q      <= 1'b0;
                        end
                    end

                    StStart: begin
                        if (decide && maj) begin
                            // Start bit high at mid-bit: treat as a line glitch.
                            state_q <= StIdle;
                        end else if (bit_end) begin
                            state_q <= StData;
                        end
                    end

                    StData: begin
                        if (decide) begin
                            for (int unsigned i = 0; i < DATA_W; i++) begin
                                if (bit_idx_q == 4'(i)) shreg_q[i] <= maj;
                            end
                            par_acc_q <= par_acc_q ^ maj;
                            if (maj) zero_q <= 1'b0;
                        end
                        if (bit_end) begin
                            if (bit_idx_q == nbits_q - 4'd1) begin
                                state_q <= par_en_q ? StParity : StStop1;
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                            end
                        end
                    end

                    StParity: begin
                        if (decide) begin
                            perr_q <= maj != (par_acc_q ^ par_odd_q);
                            if (maj) zero_q <= 1'b0;
                        end
                        if (bit_end) begin
                            state_q <= StStop1;
                        end
                    end

                    StStop1: begin
                        if (decide) begin
                            if (two_stop_q) begin
                                ferr_q <= ~maj;
                                brk_q  <= zero_q & ~maj;
                            end else begin
                                // Push at mid stop bit so a following start edge is not missed.
                                push_q      <= 1'b1;
                                push_word_q <= {zero_q & ~maj, ~maj, perr_q, shreg_q};
                                state_q     <= StIdle;
                            end
                        end
                        if (bit_end) begin
                            state_q <= StStop2;
                        end
                    end

                    StStop2: begin
                        if (decide) begin
                            push_q      <= 1'b1;
                            push_word_q <= {brk_q, ferr_q | ~maj, perr_q, shreg_q};
                            state_q     <= StIdle;
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign rx_busy = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [WordW-1:0]  mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]  wr_ptr_q;
    logic [AddrW-1:0]  rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic              overrun_q;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic [WordW-1:0]  head;

    // Push/pop qualification; a pop frees the slot a same-cycle push needs.
    always_comb begin
        full  = (count_q == CountW'(FIFO_DEPTH));
        pop   = (count_q != '0) && rd_ready;
        wr_en = push_q && (!full || pop);
        drop  = push_q && full && !pop;
        head  = mem_q[rd_ptr_q];
    end

    // Storage array, written without reset; reads are gated by occupancy.
    always_ff @(posedge PCLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_word_q;
        end
    end

    // Pointers, occupancy count and sticky overrun flag.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? head[DATA_W-1:0] : '0;
    assign rd_err     = rd_valid ? head[WordW-1:DATA_W] : '0;
    assign fifo_count = count_q;
    assign fifo_full  = full;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core_param.sv
// Self-checking bench for uart_rx_core_param: directed frames, scoreboard queue of
// expected FIFO words, and a monitor that checks every pop.

module tb_uart_rx_core_param;

    localparam int unsigned DataW = 9;
    localparam int unsigned Depth = 4;
    localparam int unsigned Osr   = 16;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic             os_tick = 1'b1;
    logic             rx_en = 1'b1;
    logic [3:0]       data_bits = 4'd8;
    logic [1:0]       parity_mode = 2'b00;
    logic             stop_bits = 1'b0;
    logic             UART_RXD = 1'b1;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [DataW-1:0] rd_data;
    logic [2:0]       rd_err;
    logic [2:0]       fifo_count;
    logic             fifo_full;
    logic             overrun;
    logic             overrun_clr = 1'b0;
    logic             rx_busy;

    int total = 0;
    int bad = 0;
    logic [11:0] exp_q[$];

    uart_rx_core_param #(
        .DATA_W(DataW),
        .FIFO_DEPTH(Depth),
        .OSR(Osr)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .os_tick(os_tick),
        .rx_en(rx_en),
        .data_bits(data_bits),
        .parity_mode(parity_mode),
        .stop_bits(stop_bits),
        .UART_RXD(UART_RXD),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .rd_err(rd_err),
        .fifo_count(fifo_count),
        .fifo_full(fifo_full),
        .overrun(overrun),
        .overrun_clr(overrun_clr),
        .rx_busy(rx_busy)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared with the scoreboard head.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge PCLK);
            if (PRESETn && rd_valid && rd_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected: got 0x%0h want none", {rd_err, rd_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({rd_err, rd_data} !== e) begin
                        bad++;
                        $display("FAIL pop_word: got 0x%0h want 0x%0h", {rd_err, rd_data}, e);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        UART_RXD = b;
        cyc(Osr);
    endtask

    task automatic idle(input int n);
        UART_RXD = 1'b1;
        cyc(n);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                              input logic pbit, input logic s1, input bit two, input logic s2);
        logic [8:0] dd;
        dd = d;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(dd[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(s1);
        if (two) drive_bit(s2);
        idle(4);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (fifo_count != 3'd0 && n < 40) begin
            cyc(1);
            n++;
        end
        rd_ready = 1'b0;
        check("drain_bound", 32'(n < 40), 32'd1);
    endtask

    initial begin
        logic saw;
        cyc(4);
        // Reset values
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_err", 32'(rd_err), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        PRESETn = 1'b1;
        idle(8);

        // 8N1 0x6D
        exp_q.push_back({3'b000, 9'h06D});
        send_frame(9'h06D, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_data", 32'(rd_data), 32'h06D);
        check("t1_err", 32'(rd_err), 32'd0);
        check("t1_count", 32'(fifo_count), 32'd1);
        drain();
        check("t1_count_after", 32'(fifo_count), 32'd0);

        // 8E2: 0x79 has five ones, so even parity bit is 1
        parity_mode = 2'b01;
        stop_bits = 1'b1;
        exp_q.push_back({3'b000, 9'h079});
        send_frame(9'h079, 8, 1, 1'b1, 1'b1, 1, 1'b1);
        exp_q.push_back({3'b001, 9'h079});
        send_frame(9'h079, 8, 1, 1'b0, 1'b1, 1, 1'b1);
        exp_q.push_back({3'b010, 9'h079});
        send_frame(9'h079, 8, 1, 1'b1, 1'b1, 1, 1'b0);
        check("t2_count", 32'(fifo_count), 32'd3);
        drain();

        // Break: line low for 12 bit periods, 8N1
        parity_mode = 2'b00;
        stop_bits = 1'b0;
        exp_q.push_back({3'b110, 9'h000});
        UART_RXD = 1'b0;
        cyc(12 * Osr);
        check("brk_count_low", 32'(fifo_count), 32'd1);
        idle(3 * Osr);
        check("brk_count_high", 32'(fifo_count), 32'd1);
        drain();

        // Glitch: 5 ticks low then high
        saw = 1'b0;
        UART_RXD = 1'b0;
        cyc(5);
        UART_RXD = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (rx_busy) saw = 1'b1;
        end
        check("glitch_busy_seen", 32'(saw), 32'd1);
        check("glitch_busy_end", 32'(rx_busy), 32'd0);
        check("glitch_count", 32'(fifo_count), 32'd0);

        // Format coverage: 7O1 (0x55 has four ones, odd parity bit 1), clamps, mode 11
        parity_mode = 2'b10;
        data_bits = 4'd7;
        exp_q.push_back({3'b000, 9'h055});
        send_frame(9'h055, 7, 1, 1'b1, 1'b1, 0, 1'b1);
        exp_q.push_back({3'b001, 9'h055});
        send_frame(9'h055, 7, 1, 1'b0, 1'b1, 0, 1'b1);
        parity_mode = 2'b11;
        data_bits = 4'd15;
        exp_q.push_back({3'b000, 9'h1A5});
        send_frame(9'h1A5, 9, 0, 1'b0, 1'b1, 0, 1'b1);
        data_bits = 4'd2;
        exp_q.push_back({3'b000, 9'h013});
        send_frame(9'h013, 5, 0, 1'b0, 1'b1, 0, 1'b1);
        check("fmt_count", 32'(fifo_count), 32'd4);
        drain();

        // FIFO overflow: five frames into four entries
        parity_mode = 2'b00;
        data_bits = 4'd8;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({3'b000, 9'(i)});
            send_frame(9'(i), 8, 0, 1'b0, 1'b1, 0, 1'b1);
        end
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_overrun", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        check("ovf_clr", 32'(overrun), 32'd0);

        // Push of 0x06 coincides with a pop while full. Push is decided at the
        // mid stop-bit sample and written one cycle later: 13 + 1 ticks in.
        exp_q.push_back({3'b000, 9'h006});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i == 1 || i == 2);
        UART_RXD = 1'b1;
        cyc(13);
        rd_ready = 1'b1;
        cyc(1);
        rd_ready = 1'b0;
        cyc(2);
        idle(4);
        check("coinc_overrun", 32'(overrun), 32'd0);
        check("coinc_count", 32'(fifo_count), 32'd4);
        check("coinc_full", 32'(fifo_full), 32'd1);
        drain();

        // rx_en dropped after data bit 3
        send_frame(9'h011, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        send_frame(9'h022, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        check("en_busy_before", 32'(rx_busy), 32'd1);
        rx_en = 1'b0;
        UART_RXD = 1'b1;
        cyc(2);
        check("en_busy_after", 32'(rx_busy), 32'd0);
        cyc(5 * Osr);
        rx_en = 1'b1;
        idle(4);
        check("en_count", 32'(fifo_count), 32'd2);
        check("en_head", 32'({rd_err, rd_data}), 32'h011);

        // Reset mid-frame with two words queued
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("rst2_busy_before", 32'(rx_busy), 32'd1);
        PRESETn = 1'b0;
        cyc(1);
        check("rst2_valid", 32'(rd_valid), 32'd0);
        check("rst2_data", 32'(rd_data), 32'd0);
        check("rst2_err", 32'(rd_err), 32'd0);
        check("rst2_count", 32'(fifo_count), 32'd0);
        check("rst2_full", 32'(fifo_full), 32'd0);
        check("rst2_busy", 32'(rx_busy), 32'd0);
        PRESETn = 1'b1;
        idle(8);

        // Recovery frame after reset
        exp_q.push_back({3'b000, 9'h05A});
        send_frame(9'h05A, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("rec_count", 32'(fifo_count), 32'd1);
        drain();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
